// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the CPU pipeline slice.
//   - ALU one-hot function codes (12 bits, one bit per operation)
//   - divider state encoding used by div_iter
//   - es_to_ms_t: payload handed from execute to memory stage
package pipe_pkg;

  localparam int PIPE_XLEN = 32;
  localparam int ALU_OP_W  = 12;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 12'h001;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 12'h002;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 12'h004;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 12'h008;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 12'h010;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 12'h020;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 12'h040;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 12'h080;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 12'h100;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 12'h200;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 12'h400;
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = 12'h800;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [PIPE_XLEN-1:0] pc;
    logic [PIPE_XLEN-1:0] result;
    logic [PIPE_XLEN-1:0] store_data;
    logic [4:0]           rd;
    logic                 gr_we;
    logic                 mem_we;
    logic                 res_from_mem;
  } es_to_ms_t;

endpackage

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring unsigned divider, one quotient bit
// per cycle.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   clear             abandon any operation and return to DIV_IDLE
//   start             begin dividing dividend by divisor (accepted in DIV_IDLE)
//   dividend, divisor operands, sampled on start
//   busy, done        FSM in DIV_BUSY / DIV_DONE
//   quotient, remainder  results, held while in DIV_DONE
// Division by zero yields quotient all-ones and remainder = dividend, which
// falls out of the restoring algorithm naturally (every trial subtract of
// zero succeeds).
module div_iter
  import pipe_pkg::*;
#(
  parameter int XLEN       = PIPE_XLEN,
  parameter int DIV_CYCLES = PIPE_XLEN
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(DIV_CYCLES);

  div_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dsor_q;

  // Partial remainder shifted left with the next dividend bit, and the trial
  // subtraction; bit XLEN of the difference is the borrow.
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;
  assign rem_sh = {rem_q, quot_q[XLEN-1]};
  assign trial  = rem_sh - {1'b0, dsor_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dsor_q  <= '0;
    end else if (clear) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dsor_q  <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            state_q <= DIV_BUSY;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= dividend;
            dsor_q  <= divisor;
          end
        end
        DIV_BUSY: begin
          // Quotient bits shift in from the right as dividend bits shift out.
          if (!trial[XLEN]) begin
            rem_q  <= trial[XLEN-1:0];
            quot_q <= {quot_q[XLEN-2:0], 1'b1};
          end else begin
            rem_q  <= rem_sh[XLEN-1:0];
            quot_q <= {quot_q[XLEN-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DIV_CYCLES - 1)) begin
            state_q <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          state_q <= DIV_DONE;
        end
        default: begin
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q == DIV_BUSY);
  assign done      = (state_q == DIV_DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute-stage slot of the 5-stage pipeline (decode -> ex -> mem).
// Captures one instruction via ds_to_es_valid/es_allowin, evaluates the
// one-hot ALU on registered operands, and hands the result to ms via
// es_to_ms_valid/ms_allowin. Bypass info (es_fwd_*) goes back to decode.
// Build option: define EX_DIV_EN to include the iterative unsigned divider
// (ds_div / ds_mod); without it those inputs are ignored and every
// instruction completes in one cycle.
// Ports: clk, resetn (async active-low), flush, decode-side ds_* inputs,
// es_allowin, ms_allowin, es_to_ms_valid + es_* payload, es_fwd_* bypass.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN       = PIPE_XLEN,
  parameter int DIV_CYCLES = PIPE_XLEN  // must equal XLEN
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                ds_to_es_valid,
  output logic                es_allowin,
  input  logic [XLEN-1:0]     ds_pc,
  input  logic [ALU_OP_W-1:0] ds_alu_op,
  input  logic [XLEN-1:0]     ds_src1,
  input  logic [XLEN-1:0]     ds_src2,
  input  logic                ds_div,
  input  logic                ds_mod,
  input  logic [4:0]          ds_rd,
  input  logic                ds_gr_we,
  input  logic                ds_mem_we,
  input  logic                ds_res_from_mem,
  input  logic [XLEN-1:0]     ds_store_data,
  input  logic                ms_allowin,
  output logic                es_to_ms_valid,
  output logic [XLEN-1:0]     es_pc,
  output logic [XLEN-1:0]     es_result,
  output logic [XLEN-1:0]     es_store_data,
  output logic [4:0]          es_rd,
  output logic                es_gr_we,
  output logic                es_mem_we,
  output logic                es_res_from_mem,
  output logic                es_fwd_valid,
  output logic [4:0]          es_fwd_rd,
  output logic [XLEN-1:0]     es_fwd_data,
  output logic                es_fwd_data_ok
);

  localparam int SHW = $clog2(XLEN);

  logic                es_valid_q, es_valid_d;
  logic [XLEN-1:0]     es_pc_q, es_src1_q, es_src2_q, es_store_data_q;
  logic [ALU_OP_W-1:0] es_alu_op_q;
  logic [4:0]          es_rd_q;
  logic                es_gr_we_q, es_mem_we_q, es_res_from_mem_q;
  logic                es_ready_go, es_capture, es_handoff;
  logic [XLEN-1:0]     alu_y, es_result_w;
  es_to_ms_t           es_payload;

  // Gated by resetn so every output reads 0 while reset is held.
  assign es_allowin     = resetn & (!es_valid_q | (es_ready_go & ms_allowin));
  assign es_capture     = ds_to_es_valid & es_allowin & !flush;
  assign es_to_ms_valid = es_valid_q & es_ready_go & !flush;
  assign es_handoff     = es_to_ms_valid & ms_allowin;

  // Flush wins over capture; capture wins over handoff (replacement).
  always_comb begin
    es_valid_d = es_valid_q;
    if (flush) begin
      es_valid_d = 1'b0;
    end else if (es_capture) begin
      es_valid_d = 1'b1;
    end else if (es_handoff) begin
      es_valid_d = 1'b0;
    end
  end

`ifdef EX_DIV_EN
  logic es_div_q, es_mod_q;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid_q        <= 1'b0;
      es_pc_q           <= '0;
      es_alu_op_q       <= '0;
      es_src1_q         <= '0;
      es_src2_q         <= '0;
      es_rd_q           <= '0;
      es_gr_we_q        <= 1'b0;
      es_mem_we_q       <= 1'b0;
      es_res_from_mem_q <= 1'b0;
      es_store_data_q   <= '0;
`ifdef EX_DIV_EN
      es_div_q          <= 1'b0;
      es_mod_q          <= 1'b0;
`endif
    end else begin
      es_valid_q <= es_valid_d;
      if (es_capture) begin
        es_pc_q           <= ds_pc;
        es_alu_op_q       <= ds_alu_op;
        es_src1_q         <= ds_src1;
        es_src2_q         <= ds_src2;
        es_rd_q           <= ds_rd;
        es_gr_we_q        <= ds_gr_we;
        es_mem_we_q       <= ds_mem_we;
        es_res_from_mem_q <= ds_res_from_mem;
        es_store_data_q   <= ds_store_data;
`ifdef EX_DIV_EN
        es_div_q          <= ds_div;
        es_mod_q          <= ds_mod;
`endif
      end
    end
  end

  // ALU on registered operands.
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] add_y, sub_y, sra_y;
  logic            slt_y, sltu_y;
  assign shamt  = es_src2_q[SHW-1:0];
  assign add_y  = es_src1_q + es_src2_q;
  assign sub_y  = es_src1_q - es_src2_q;
  // Kept separate so the shift stays arithmetic (signed context).
  assign sra_y  = $signed(es_src1_q) >>> shamt;
  assign slt_y  = $signed(es_src1_q) < $signed(es_src2_q);
  assign sltu_y = es_src1_q < es_src2_q;

  always_comb begin
    alu_y = '0;
    case (es_alu_op_q)
      ALU_ADD:  alu_y = add_y;
      ALU_SUB:  alu_y = sub_y;
      ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, sltu_y};
      ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, slt_y};
      ALU_AND:  alu_y = es_src1_q & es_src2_q;
      ALU_OR:   alu_y = es_src1_q | es_src2_q;
      ALU_NOR:  alu_y = ~(es_src1_q | es_src2_q);
      ALU_XOR:  alu_y = es_src1_q ^ es_src2_q;
      ALU_SLL:  alu_y = es_src1_q << shamt;
      ALU_SRL:  alu_y = es_src1_q >> shamt;
      ALU_SRA:  alu_y = sra_y;
      ALU_LUI:  alu_y = es_src2_q;
      default:  alu_y = '0;
    endcase
  end

`ifdef EX_DIV_EN
  logic            div_start, div_clear, div_busy, div_done;
  logic [XLEN-1:0] div_quot, div_rem;

  // Start one cycle after capture; a new capture, a handoff or a flush all
  // discard whatever the divider was holding.
  assign div_start   = es_valid_q & (es_div_q | es_mod_q) & !div_busy & !div_done & !flush;
  assign div_clear   = flush | es_capture | es_handoff;
  assign es_ready_go = !(es_div_q | es_mod_q) | div_done;

  div_iter #(
    .XLEN       (XLEN),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_iter (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (div_clear),
    .start     (div_start),
    .dividend  (es_src1_q),
    .divisor   (es_src2_q),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  always_comb begin
    es_result_w = alu_y;
    if (es_div_q) begin
      es_result_w = div_quot;
    end else if (es_mod_q) begin
      es_result_w = div_rem;
    end
  end
`else
  logic unused_div;
  assign unused_div  = ds_div ^ ds_mod ^ (DIV_CYCLES != XLEN);
  assign es_ready_go = 1'b1;
  assign es_result_w = alu_y;
`endif

  assign es_payload = '{
    pc:           es_pc_q,
    result:       es_result_w,
    store_data:   es_store_data_q,
    rd:           es_rd_q,
    gr_we:        es_gr_we_q,
    mem_we:       es_mem_we_q,
    res_from_mem: es_res_from_mem_q
  };

  assign es_pc           = es_payload.pc;
  assign es_result       = es_payload.result;
  assign es_store_data   = es_payload.store_data;
  assign es_rd           = es_payload.rd;
  assign es_gr_we        = es_payload.gr_we;
  assign es_mem_we       = es_payload.mem_we;
  assign es_res_from_mem = es_payload.res_from_mem;

  assign es_fwd_valid   = es_valid_q & es_gr_we_q & (es_rd_q != 5'd0);
  assign es_fwd_rd      = es_rd_q;
  assign es_fwd_data    = es_result_w;
  assign es_fwd_data_ok = es_fwd_valid & !es_res_from_mem_q & es_ready_go;

endmodule

// File: tb/tb_ex_stage.sv
`timescale 1ns/1ps
module tb_ex_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        flush = 1'b0;
  logic        ds_to_es_valid = 1'b0;
  logic        es_allowin;
  logic [31:0] ds_pc = '0;
  logic [11:0] ds_alu_op = '0;
  logic [31:0] ds_src1 = '0, ds_src2 = '0, ds_store_data = '0;
  logic        ds_div = 1'b0, ds_mod = 1'b0;
  logic [4:0]  ds_rd = '0;
  logic        ds_gr_we = 1'b0, ds_mem_we = 1'b0, ds_res_from_mem = 1'b0;
  logic        ms_allowin = 1'b1;
  logic        es_to_ms_valid;
  logic [31:0] es_pc, es_result, es_store_data, es_fwd_data;
  logic [4:0]  es_rd, es_fwd_rd;
  logic        es_gr_we, es_mem_we, es_res_from_mem;
  logic        es_fwd_valid, es_fwd_data_ok;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .ds_pc(ds_pc), .ds_alu_op(ds_alu_op), .ds_src1(ds_src1), .ds_src2(ds_src2),
    .ds_div(ds_div), .ds_mod(ds_mod), .ds_rd(ds_rd), .ds_gr_we(ds_gr_we),
    .ds_mem_we(ds_mem_we), .ds_res_from_mem(ds_res_from_mem),
    .ds_store_data(ds_store_data), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc), .es_result(es_result),
    .es_store_data(es_store_data), .es_rd(es_rd), .es_gr_we(es_gr_we),
    .es_mem_we(es_mem_we), .es_res_from_mem(es_res_from_mem),
    .es_fwd_valid(es_fwd_valid), .es_fwd_rd(es_fwd_rd),
    .es_fwd_data(es_fwd_data), .es_fwd_data_ok(es_fwd_data_ok)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        gr_we;
    logic        mem_we;
    logic        res_from_mem;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_hand = 0;

  logic [144:0] all_outs;
  assign all_outs = {es_allowin, es_to_ms_valid, es_pc, es_result, es_store_data,
                     es_rd, es_gr_we, es_mem_we, es_res_from_mem, es_fwd_valid,
                     es_fwd_rd, es_fwd_data, es_fwd_data_ok};

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] req);
    n_vec++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Monitor: every handoff to ms is compared against the oldest expectation.
  initial begin : monitor
    exp_t e;
    exp_t g;
    forever begin
      @(negedge clk);
      if (es_to_ms_valid && ms_allowin) begin
        n_hand++;
        g = '{pc: es_pc, result: es_result, store_data: es_store_data, rd: es_rd,
              gr_we: es_gr_we, mem_we: es_mem_we, res_from_mem: es_res_from_mem};
        $display("handoff pc=%h result=%h rd=%0d", es_pc, es_result, es_rd);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL handoff_unexpected: got pc=%h result=%h, required no handoff", es_pc, es_result);
        end else begin
          e = exp_q.pop_front();
          check("handoff_payload", g, e);
        end
      end
    end
  end

  task automatic set_instr(input logic [31:0] pc, input logic [11:0] op,
                           input logic [31:0] s1, input logic [31:0] s2,
                           input logic dv, input logic md, input logic [4:0] rd,
                           input logic gw, input logic mw, input logic rfm,
                           input logic [31:0] sd);
    ds_to_es_valid = 1'b1; ds_pc = pc; ds_alu_op = op; ds_src1 = s1; ds_src2 = s2;
    ds_div = dv; ds_mod = md; ds_rd = rd; ds_gr_we = gw; ds_mem_we = mw;
    ds_res_from_mem = rfm; ds_store_data = sd;
  endtask

  // Present an instruction until ex accepts it; optionally queue its result.
  task automatic issue(input logic [31:0] pc, input logic [11:0] op,
                       input logic [31:0] s1, input logic [31:0] s2,
                       input logic dv, input logic md, input logic [4:0] rd,
                       input logic gw, input logic mw, input logic rfm,
                       input logic [31:0] exp_res, input bit do_push);
    bit taken;
    int guard;
    set_instr(pc, op, s1, s2, dv, md, rd, gw, mw, rfm, ~pc);
    if (do_push)
      exp_q.push_back('{pc: pc, result: exp_res, store_data: ~pc, rd: rd,
                        gr_we: gw, mem_we: mw, res_from_mem: rfm});
    taken = 1'b0;
    guard = 0;
    while (!taken && guard < 100) begin
      @(negedge clk);
      taken = es_allowin && !flush;
      @(posedge clk); #1;
      guard++;
    end
    ds_to_es_valid = 1'b0;
    if (!taken) begin
      n_vec++;
      n_bad++;
      $display("FAIL issue_timeout pc=%h: got no acceptance in 100 cycles, required acceptance", pc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Count edges from capture until es_to_ms_valid; note any early data_ok.
  task automatic wait_valid(output int lat, output logic early_ok);
    lat = 0;
    early_ok = 1'b0;
    @(negedge clk);
    while (!es_to_ms_valid && lat < 60) begin
      early_ok = early_ok | es_fwd_data_ok;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  logic [11:0] vop [12];
  logic [31:0] va [12];
  logic [31:0] vb [12];
  logic [31:0] vy [12];

  initial begin : stim
    int h0;
    int lat;
    logic early;

    vop = '{ALU_ADD, ALU_SUB, ALU_SLTU, ALU_SLT, ALU_AND, ALU_OR,
            ALU_NOR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI};
    va  = '{32'hFFFF_FFFF, 32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
            32'h0, 32'hAAAA_5555, 32'h1, 32'h8000_0000, 32'h8000_0000, 32'hDEAD};
    vb  = '{32'h1, 32'd3, 32'h1, 32'h1, 32'hFF00_FF00, 32'h0F0F_0000,
            32'h0, 32'hFFFF_0000, 32'd31, 32'd4, 32'd4, 32'h1234_5000};
    vy  = '{32'h0, 32'd7, 32'h0, 32'h1, 32'hF000_F000, 32'hFFFF_F0F0,
            32'hFFFF_FFFF, 32'h5555_5555, 32'h8000_0000, 32'h0800_0000, 32'hF800_0000, 32'h1234_5000};

    // Reset
    #2 resetn = 1'b0;
    #1 check("reset_outputs", all_outs, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("allowin_after_reset", es_allowin, 1);
    @(posedge clk); #1;

    // ADD_SUB_PIPELINE
    ms_allowin = 1'b1;
    issue(32'h1000, ALU_ADD, 32'd5, 32'd7, 0, 0, 5'd1, 1, 0, 0, 32'd12, 1);
    @(negedge clk);
    check("add_one_cycle_valid", es_to_ms_valid, 1);
    check("add_result", es_result, 32'd12);
    check("add_fwd_data_ok", es_fwd_data_ok, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      set_instr(32'h2000 + 32'(4 * i), vop[i], va[i], vb[i], 0, 0, 5'(i + 1), 1, 0, 0, ~(32'h2000 + 32'(4 * i)));
      exp_q.push_back('{pc: 32'h2000 + 32'(4 * i), result: vy[i], store_data: ~(32'h2000 + 32'(4 * i)),
                        rd: 5'(i + 1), gr_we: 1'b1, mem_we: 1'b0, res_from_mem: 1'b0});
      @(negedge clk);
      check("b2b_allowin", es_allowin, 1);
      @(posedge clk); #1;
    end
    ds_to_es_valid = 1'b0;
    idle(2);

    // MS_STALL
    ms_allowin = 1'b0;
    h0 = n_hand;
    issue(32'h3000, ALU_SUB, 32'd3, 32'd5, 0, 0, 5'd2, 1, 0, 0, 32'hFFFF_FFFE, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_result", es_result, 32'hFFFF_FFFE);
      check("stall_allowin", es_allowin, 0);
      check("stall_valid", es_to_ms_valid, 1);
      @(posedge clk); #1;
    end
    ms_allowin = 1'b1;
    idle(2);
    @(negedge clk);
    check("stall_single_handoff", n_hand - h0, 1);
    @(posedge clk); #1;

    // Flush a held instruction; flush also beats a same-cycle offer
    ms_allowin = 1'b0;
    issue(32'h4000, ALU_ADD, 32'd1, 32'd2, 0, 0, 5'd3, 1, 0, 0, 32'd3, 0);
    flush = 1'b1;
    set_instr(32'h4100, ALU_ADD, 32'd9, 32'd9, 0, 0, 5'd5, 1, 0, 0, 32'h0);
    @(negedge clk);
    check("flush_blocks_valid", es_to_ms_valid, 0);
    @(posedge clk); #1;
    ds_to_es_valid = 1'b1;
    @(negedge clk);
    check("flush_cleared_allowin", es_allowin, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    ds_to_es_valid = 1'b0;
    ms_allowin = 1'b1;
    @(negedge clk);
    check("flush_over_capture", {es_fwd_valid, es_to_ms_valid}, 2'b00);
    @(posedge clk); #1;
    issue(32'h4300, ALU_ADD, 32'h40, 32'h2, 0, 0, 5'd7, 1, 0, 0, 32'h42, 1);
    @(negedge clk);
    check("add_after_flush_valid", es_to_ms_valid, 1);
    @(posedge clk); #1;

`ifdef EX_DIV_EN
    // DIVIDE_LATENCY / DIVIDE_BY_ZERO
    issue(32'h5000, ALU_ADD, 32'd100, 32'd7, 1, 0, 5'd8, 1, 0, 0, 32'd14, 1);
    wait_valid(lat, early);
    check("div_latency", lat, 33);
    check("div_fwd_ok_early", early, 0);
    check("div_fwd_ok_done", es_fwd_data_ok, 1);
    @(posedge clk); #1;
    issue(32'h5004, ALU_ADD, 32'd100, 32'd7, 0, 1, 5'd9, 1, 0, 0, 32'd2, 1);
    wait_valid(lat, early);
    check("mod_latency", lat, 33);
    @(posedge clk); #1;
    issue(32'h5008, ALU_ADD, 32'h1234, 32'h0, 1, 0, 5'd10, 1, 0, 0, 32'hFFFF_FFFF, 1);
    wait_valid(lat, early);
    check("div0_latency", lat, 33);
    @(posedge clk); #1;
    issue(32'h500C, ALU_ADD, 32'h1234, 32'h0, 0, 1, 5'd11, 1, 0, 0, 32'h1234, 1);
    wait_valid(lat, early);
    @(posedge clk); #1;

    // FLUSH_MID_DIV
    issue(32'h6000, ALU_ADD, 32'd1000, 32'd3, 1, 0, 5'd9, 1, 0, 0, 32'd333, 0);
    idle(9);
    flush = 1'b1;
    @(negedge clk);
    check("flush_div_no_valid", es_to_ms_valid, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_div_idle", {es_allowin, es_fwd_valid, es_to_ms_valid}, 3'b100);
    @(posedge clk); #1;
    issue(32'h6100, ALU_ADD, 32'd20, 32'd22, 0, 0, 5'd12, 1, 0, 0, 32'd42, 1);
    @(negedge clk);
    check("add_after_div_flush", es_to_ms_valid, 1);
    @(posedge clk); #1;
`else
    // Without the divider, divide flags are ignored
    issue(32'h5000, ALU_ADD, 32'd100, 32'd7, 1, 0, 5'd8, 1, 0, 0, 32'd107, 1);
    @(negedge clk);
    check("div_ignored_one_cycle", es_to_ms_valid, 1);
    @(posedge clk); #1;
    issue(32'h5004, ALU_SUB, 32'd100, 32'd7, 0, 1, 5'd9, 1, 0, 0, 32'd93, 1);
    idle(1);
`endif

    // BYPASS_AND_RESET
    ms_allowin = 1'b0;
    issue(32'h7000, ALU_ADD, 32'h100, 32'h20, 0, 0, 5'd4, 1, 0, 1, 32'h120, 1);
    @(negedge clk);
    check("load_fwd", {es_fwd_valid, es_fwd_rd, es_fwd_data_ok}, {1'b1, 5'd4, 1'b0});
    check("load_fwd_data", es_fwd_data, 32'h120);
    @(posedge clk); #1;
    ms_allowin = 1'b1;
    idle(1);
    ms_allowin = 1'b0;
    issue(32'h7100, ALU_OR, 32'h5, 32'h0, 0, 0, 5'd0, 1, 0, 0, 32'h5, 1);
    @(negedge clk);
    check("rd0_fwd_valid", es_fwd_valid, 0);
    @(posedge clk); #1;
    ms_allowin = 1'b1;
    idle(1);
    issue(32'h7200, ALU_ADD, 32'h8000, 32'h10, 0, 0, 5'd6, 0, 1, 0, 32'h8010, 1);
    idle(2);

`ifdef EX_DIV_EN
    issue(32'h7300, ALU_ADD, 32'd50, 32'd5, 1, 0, 5'd13, 1, 0, 0, 32'd10, 0);
    idle(5);
`else
    ms_allowin = 1'b0;
    issue(32'h7300, ALU_ADD, 32'h11, 32'h22, 0, 0, 5'd13, 1, 0, 0, 32'h33, 0);
`endif
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 check("async_reset_outputs", all_outs, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    ms_allowin = 1'b1;
    @(negedge clk);
    check("after_reset_idle", {es_allowin, es_to_ms_valid}, 2'b10);
    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
